alu_logic_pipe: RTL
===================

// Module: alu_logic_pipe
// PURPOSE
//  Two-stage pipelined bitwise unit at the ALU's operand front end. It accepts
//  operands and an opcode on a valid/ready handshake and computes AND (via the
//  existing and_gate instance), OR, XOR or NAND. It presents a registered result
//  with a zero flag to the downstream result consumer. Sustains 1 op/cycle under
//  full flow and stalls cleanly under backpressure.
// PARAMETERS
//  WIDTH     4   operand/result width in bits
//  CNT_W     8   width of the completed-operation counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        upstream presents A/B/op
//  in_ready   out  1        block can accept this cycle
//  A          in   WIDTH    operand A
//  B          in   WIDTH    operand B
//  op         in   2        00 AND, 01 OR, 10 XOR, 11 NAND
//  out_valid  out  1        result/zero valid
//  out_ready  in   1        downstream accepts this cycle
//  result     out  WIDTH    registered logic result
//  zero       out  1        1 when result == 0
//  op_count   out  CNT_W    number of completed output transfers, wraps
// BEHAVIOUR
//  - Reset: s0_valid=0, s1_valid (=out_valid)=0, result=0, zero=0, op_count=0.
//    in_ready=0 while rst=1. All in-flight data is dropped when rst is asserted
//    mid-operation. The first accept is possible on the first cycle with rst=0.
//  - Transfers: input on in_valid&in_ready at a clk edge. Output on
//    out_valid&out_ready at a clk edge.
//  - Stage 0 (operand reg): latches A, B, op and sets s0_valid on an input transfer.
//  - Stage 1 (result reg): latches f(A,B,op), zero=(f==0) and sets s1_valid when
//    s0 advances.
//  - adv1 = s0_valid & (!s1_valid | out_ready)
//  - in_ready = !rst & (!s0_valid | adv1)
//  - s0_valid is cleared when adv1 occurs with no new input transfer.
//  - s1_valid is cleared on an output transfer when adv1=0.
//  - Latency: accept at edge N gives out_valid=1 after edge N+1 (2 edges).
//  - Throughput: with out_ready held 1, one result per cycle with no bubbles.
//  - Backpressure: with out_ready=0 and both stages full, in_ready=0. result,
//    zero and out_valid hold stable until the output transfer. Order is strictly
//    FIFO and no operation is ever dropped or duplicated.
//  - Simultaneous in/out transfer on a full pipe: both stages advance in the same
//    edge.
//  - Widths: all ops are bitwise, WIDTH in gives WIDTH out, no carry. NAND =
//    ~(A&B) masked to WIDTH.
//  - op_count increments by 1 on every output transfer and wraps 2^CNT_W-1 -> 0.
//  - Inputs are don't-care when in_valid=0. No X may propagate to result while
//    out_valid=1.
// STRUCTURE
//  - Shared header alu_defs.vh: `define opcodes OP_AND=2'b00, OP_OR=2'b01,
//    OP_XOR=2'b10, OP_NAND=2'b11, plus the default WIDTH.
//  - AND path instantiates the existing and_gate (ports A, B, result).
//    OR/XOR/NAND are inline.
//  - One natural sub-module: alu_pipe_reg. It is a WIDTH-parameterised
//    valid/ready register slice (data, valid, ready-propagation) and is
//    instantiated twice.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> out_valid=0, result=0000, zero=0,
//     op_count=0, in_ready=0. After release, in_ready=1.
//  2. AND: A=1010 B=1011 op=00 with out_ready=1 -> result=1010, zero=0 two edges
//     later. Then A=0000 B=1111 op=00 -> result=0000, zero=1.
//  3. Op coverage: A=1100 B=1010 with op=01/10/11 -> 1110 / 0110 / 0111.
//  4. Backpressure: out_ready=0, issue 3 ops -> in_ready=0 after 2 accepts and
//     the 1st result is held stable. Raise out_ready -> results emerge in issue
//     order, none lost, op_count=3.
//  5. Streaming: 16 back-to-back ops with out_ready=1 -> 16 consecutive
//     out_valid cycles. Assert rst mid-stream -> out_valid=0 the next cycle and
//     no stale result after release.
//  6. Counter wrap: 256 output transfers -> op_count returns to 0.

Source files
------------

// File: rtl/alu_logic_pipe_pkg.sv
// Shared opcode encoding and default sizes for the two-stage bitwise pipe.
`timescale 1ns/1ps
package alu_logic_pipe_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned OP_W      = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

endpackage

// File: rtl/alu_logic_pipe_reg.sv
// One valid/ready register slice; accepts whenever empty or draining this cycle.
`timescale 1ns/1ps
module alu_logic_pipe_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;
   logic         w_load;

   assign o_ready = !r_valid | i_ready;
   assign w_load  = i_valid & o_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Data is reset too so nothing unknown is ever visible downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/and_gate.sv
// Width-parameterised bitwise AND used as the AND path of the logic pipe.
`timescale 1ns/1ps
module and_gate #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result
);

   assign result = A & B;

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage pipelined AND/OR/XOR/NAND unit with zero flag and output counter.
`timescale 1ns/1ps
module alu_logic_pipe
   import alu_logic_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned S0_W = 2 * WIDTH + OP_W;
   localparam int unsigned S1_W = WIDTH + 1;

   logic [S0_W-1:0]  w_s0_din;
   logic [S0_W-1:0]  w_s0_dout;
   logic             w_s0_valid;
   logic             w_s0_ready;
   logic             w_s1_ready;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [OP_W-1:0]  w_op;
   logic [WIDTH-1:0] w_and;
   logic [WIDTH-1:0] w_f;
   logic             w_zero;
   logic [S1_W-1:0]  w_s1_din;
   logic [S1_W-1:0]  w_s1_dout;
   logic [CNT_W-1:0] r_op_count;

   assign w_s0_din = {A, B, op};
   assign in_ready = !rst & w_s0_ready;

   alu_logic_pipe_reg #(.W(S0_W)) u_s0 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid),
      .o_ready (w_s0_ready),
      .i_data  (w_s0_din),
      .o_valid (w_s0_valid),
      .i_ready (w_s1_ready),
      .o_data  (w_s0_dout)
   );

   assign {w_a, w_b, w_op} = w_s0_dout;

   and_gate #(.WIDTH(WIDTH)) u_and (
      .A      (w_a),
      .B      (w_b),
      .result (w_and)
   );

   // Operation select between the operand and result registers.
   always_comb begin
      w_f = '0;
      case (op_e'(w_op))
         OP_AND:  w_f = w_and;
         OP_OR:   w_f = w_a | w_b;
         OP_XOR:  w_f = w_a ^ w_b;
         OP_NAND: w_f = ~(w_a & w_b);
      endcase
   end

   assign w_zero   = (w_f == '0);
   assign w_s1_din = {w_f, w_zero};

   alu_logic_pipe_reg #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_s0_valid),
      .o_ready (w_s1_ready),
      .i_data  (w_s1_din),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_s1_dout)
   );

   assign {result, zero} = w_s1_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (out_valid && out_ready) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign op_count = r_op_count;

endmodule
